// File: rtl/strob_gen.sv
// strob_gen - programmable strobe source for the AES counter test path.
//
// Issues a run of single-cycle strobes separated by a programmable gap.
// A run length of 0 means 2^CNT_W strobes, so the 10-bit downstream
// strobe checker sees one full wrap.
//
// Optional feature macro: STROB_GEN_DATA_EN
//   defined   : a DATA_W-bit Fibonacci LFSR (reset to SEED) supplies a new
//               test word on data_out with every strobe; data_out holds
//               between strobes.
//   undefined : no LFSR, data_out is constant 0.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   reset        in   synchronous active-high reset
//   start        in   run request, accepted only in IDLE
//   num_strobes  in   run length (0 = 2^CNT_W), latched on accepted start
//   gap          in   idle cycles between strobes, latched on accepted start
//   stall        in   back-pressure, blocks a due strobe while high
//   o_strob      out  registered single-cycle strobe
//   data_out     out  test word, valid in o_strob cycles
//   busy         out  run in progress
//   done         out  one-cycle pulse after the last strobe of a run
//
// state | meaning
// IDLE  | waiting for start, busy=0
// RUN   | counting gaps and issuing strobes, busy=1
// DONE  | one-cycle done pulse, start not accepted

module strob_gen #(
  parameter int unsigned    CNT_W  = 10,
  parameter int unsigned    GAP_W  = 8,
  parameter int unsigned    DATA_W = 128,
  parameter logic [DATA_W-1:0] SEED = 128'h0123456789ABCDEFFEDCBA9876543210
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_strobes,
  input  logic [GAP_W-1:0]  gap,
  input  logic              stall,
  output logic              o_strob,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W:0]   remaining;
  logic [GAP_W-1:0] gap_reg;
  logic [GAP_W-1:0] gap_cnt;
  logic             issue;

  // A strobe is issued on this edge; it appears on o_strob next cycle.
  assign issue = (state == RUN) && (remaining != '0) && (gap_cnt == '0) && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      o_strob   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      gap_reg   <= '0;
      gap_cnt   <= '0;
    end else begin
      o_strob <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= (num_strobes == '0) ? {1'b1, {CNT_W{1'b0}}}
                                             : {1'b0, num_strobes};
            gap_reg   <= gap;
            gap_cnt   <= gap;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // remaining hits 0 on the edge issuing the last strobe; the strobe
          // cycle itself still shows busy, and the done pulse follows it.
          if (remaining == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (issue) begin
            o_strob   <= 1'b1;
            remaining <= remaining - 1'b1;
            gap_cnt   <= gap_reg;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STROB_GEN_DATA_EN
  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] data_q;
  logic              fb;

  assign fb       = lfsr[DATA_W-1] ^ lfsr[28] ^ lfsr[26] ^ lfsr[1];
  assign data_out = data_q;

  // The current LFSR state is presented with each strobe, then advanced,
  // so the first strobe after reset shows SEED.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr   <= SEED;
      data_q <= SEED;
    end else if (issue) begin
      data_q <= lfsr;
      lfsr   <= {lfsr[DATA_W-2:0], fb};
    end
  end
`else
  assign data_out = '0;
`endif

endmodule

// File: tb/tb_strob_gen.sv
// Directed bench for strob_gen: hand-computed strobe/busy/done timelines,
// data_out checked against a reference LFSR when STROB_GEN_DATA_EN is set.
module tb_strob_gen;

  localparam logic [127:0] SEED = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [9:0]   num_strobes;
  logic [7:0]   gap;
  logic         stall;
  logic         o_strob;
  logic [127:0] data_out;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] lfsr_m;
  logic [127:0] held_m;

  strob_gen dut (
    .clk(clk), .reset(reset), .start(start), .num_strobes(num_strobes),
    .gap(gap), .stall(stall), .o_strob(o_strob), .data_out(data_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lfsr_next(input logic [127:0] d);
    return {d[126:0], d[127] ^ d[28] ^ d[26] ^ d[1]};
  endfunction

  task automatic model_reset();
`ifdef STROB_GEN_DATA_EN
    lfsr_m = SEED;
    held_m = SEED;
`else
    lfsr_m = SEED;
    held_m = '0;
`endif
  endtask

  // Check one cycle against the expected strobe/busy/done values.
  task automatic chk_cycle(input string tag, input logic es, input logic eb, input logic ed);
`ifdef STROB_GEN_DATA_EN
    if (es) begin
      held_m = lfsr_m;
      lfsr_m = lfsr_next(lfsr_m);
    end
`endif
    chk({tag, ".strob"}, o_strob, es);
    chk({tag, ".busy"},  busy,    eb);
    chk({tag, ".done"},  done,    ed);
    chk({tag, ".data"},  data_out, held_m);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_strobes = '0; gap = '0; stall = 1'b0;
    model_reset();
    step(); step();
    chk_cycle("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_cycle("idle", 1'b0, 1'b0, 1'b0);

    // Run 1: 3 strobes, gap 2 -> strobes at t+4,7,10, done t+11.
    start = 1'b1; num_strobes = 10'd3; gap = 8'd2;
    step();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      chk_cycle($sformatf("r1.c%0d", k), (k == 4 || k == 7 || k == 10),
                (k >= 1 && k <= 10), (k == 11));
      step();
    end

    // Run 2: num 0, gap 0 -> 1024 back-to-back strobes t+2..t+1025, done t+1026.
    start = 1'b1; num_strobes = 10'd0; gap = 8'd0;
    step();
    start = 1'b0;
    for (int k = 1; k <= 1028; k++) begin
      chk_cycle($sformatf("r2.c%0d", k), (k >= 2 && k <= 1025),
                (k >= 1 && k <= 1025), (k == 1026));
      step();
    end

    // Run 3: 2 strobes, gap 1, stall sampled high at edges t+1..t+5.
    // First due at edge t+2, released at edge t+6 -> strobes t+7, t+9.
    start = 1'b1; num_strobes = 10'd2; gap = 8'd1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      stall = (k <= 5);
      chk_cycle($sformatf("r3.c%0d", k), (k == 7 || k == 9),
                (k >= 1 && k <= 9), (k == 10));
      step();
    end
    stall = 1'b0;

    // Run 4: 2 strobes, gap 3; a start with other settings while busy is ignored.
    start = 1'b1; num_strobes = 10'd2; gap = 8'd3;
    step();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin start = 1'b1; num_strobes = 10'd5; gap = 8'd0; end
      else start = 1'b0;
      chk_cycle($sformatf("r4.c%0d", k), (k == 5 || k == 9),
                (k >= 1 && k <= 9), (k == 10));
      step();
    end
    start = 1'b0;

    // Run 5: 5 strobes, gap 1 -> strobes t+3,5,...; reset after the 2nd.
    start = 1'b1; num_strobes = 10'd5; gap = 8'd1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk_cycle($sformatf("r5.c%0d", k), (k == 3 || k == 5), 1'b1, 1'b0);
      if (k < 5) step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk_cycle("r5.rst", 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_cycle($sformatf("r5.post%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Fresh 5-strobe run after reset: strobes t+3,5,7,9,11, done t+12.
    start = 1'b1; num_strobes = 10'd5; gap = 8'd1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      chk_cycle($sformatf("r6.c%0d", k),
                (k == 3 || k == 5 || k == 7 || k == 9 || k == 11),
                (k >= 1 && k <= 11), (k == 12));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/strob_gen.md
# strob_gen

Programmable strobe source for the AES counter test path. Issues a run of single-cycle `o_strob` pulses with a programmable gap and a programmable run length. Each pulse can carry an optional 128-bit pseudo-random test word. It drives the strobe input of the 10-bit strobe-counting checker, which flags every 1024th strobe. A run length of 0 therefore means a full 1024-strobe wrap.

## Interface
Parameters:
- `CNT_W`, 10, width of run-length field; 0 encodes 2^CNT_W strobes
- `GAP_W`, 8, width of gap field
- `DATA_W`, 128, test-word width
- `SEED`, 128'h0123456789ABCDEFFEDCBA9876543210, LFSR reset value; must be nonzero

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `start`  in  1  run request, sampled only when idle
- `num_strobes`  in  CNT_W  strobes in run; latched on accepted start
- `gap`  in  GAP_W  idle cycles between strobes; latched on accepted start
- `stall`  in  1  back-pressure; high blocks issuing a strobe
- `o_strob`  out  1  registered single-cycle strobe
- `data_out`  out  DATA_W  test word, valid in `o_strob` cycles
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse after last strobe of a run

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `busy`=0.
  - `start`=1 latches `num_strobes` into `remaining`; value 0 loads 2^CNT_W, held in a CNT_W+1-bit counter.
  - It also latches `gap` into `gap_reg` and loads `gap_cnt` with `gap_reg`.
  - Next state is RUN.
- RUN:
  - `busy`=1. `start` is ignored.
  - Each edge: if `gap_cnt`≠0, decrement it. If `gap_cnt`=0 and `stall`=0, assert `o_strob` for the next cycle, decrement `remaining`, and reload `gap_cnt` with `gap_reg`.
  - If `gap_cnt`=0 and `stall`=1, hold everything and issue no strobe.
  - When the issued strobe makes `remaining` reach 0, next state is DONE. That strobe cycle is the last cycle with `busy`=1.
- DONE:
  - `done`=1 and `busy`=0 for exactly one cycle, then IDLE.
  - `start` in the DONE cycle is not accepted; it must be held or re-asserted in IDLE.
- Strobes are never back-to-back unless `gap`=0. With `gap`=0 and `stall` low, `o_strob` stays high continuously for the whole run.
- `stall` only delays strobes; it never drops or duplicates one.
- Reset mid-run:
  - Returns to IDLE and clears `o_strob`, `busy`, `done` and `remaining`.
  - The LFSR returns to `SEED`.
  - The partial run is abandoned, with no `done` pulse.
- Reset values: `o_strob`=0, `busy`=0, `done`=0, `data_out`=0 when `STROB_GEN_DATA_EN` is undefined, `SEED` when it is defined.

## Timing
- `start` is sampled at edge t. `busy`=1 from cycle t+1.
- With `stall` low throughout, strobe k (k=0..N-1) is high in cycle t+2+gap+k·(gap+1).
- With `gap`=0, the first strobe is in cycle t+2.
- `done` is high in the cycle after the last strobe.
- `stall` is sampled at the edge that would issue the strobe. Deassertion at edge e yields the strobe in cycle e+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `STROB_GEN_DATA_EN`.
- Defined:
  - A DATA_W-bit Fibonacci LFSR resets to `SEED`.
  - The first strobe after reset presents `SEED` on `data_out`.
  - The LFSR advances exactly one step per issued strobe: shift left, bit0 = d[127]^d[28]^d[26]^d[1].
  - LFSR state persists across runs and is reset only by `reset`.
  - `data_out` holds its value between strobes.
- Undefined: no LFSR is synthesized, and `data_out` is constant 0.
- Strobe and handshake timing are identical in both builds.

## Test plan
- Reset, then `start` with `num_strobes`=3 and `gap`=2 at edge t, `stall`=0 -> `o_strob` high in cycles t+4, t+7, t+10 only; `done` high in t+11; `busy` high t+1..t+10.
- `num_strobes`=0, `gap`=0 -> exactly 1024 consecutive `o_strob` cycles, then one `done`. A 10-bit counter starting at 0 returns to 0.
- `num_strobes`=2, `gap`=1, `stall` high for 5 cycles spanning the first due strobe -> exactly 2 strobes issued, the first in the cycle after `stall` falls, the second 2 cycles later.
- `start` pulsed again while `busy`=1 -> ignored: strobe count and `gap` unchanged, single `done`.
- `reset` asserted after the 2nd of 5 strobes -> all outputs 0 next cycle, no `done`. A new `start` runs 5 fresh strobes.
- With `STROB_GEN_DATA_EN`: the first strobe shows `SEED`, and each later strobe shows the single-step LFSR successor, matched against a model. Without the macro, `data_out`=0 in every cycle.
